// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch port and the
// data port, with data priority, bounded fetch starvation and a bus watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | bus free, arbitrating between pending requests
// GRANT_D | data transaction driven on the bus, waiting for bus_ack
// GRANT_I | fetch transaction driven on the bus, waiting for bus_ack
// RESP    | completion ack presented to the requester for one cycle
module mem_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        arb_pause,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam int         WD_LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [7:0] WD_LIMIT   = 8'(WD_LAST);
    localparam bit         WD_EN      = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  wd_cnt_q, wd_cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        bus_err_q, bus_err_d;

    logic        d_wins;
    logic        wd_hit;

    // Fetch only overtakes a pending data request once the streak limit is hit.
    assign d_wins = d_req && !(if_req && (streak_q == STREAK_MAX));
    assign wd_hit = WD_EN && (wd_cnt_q == WD_LIMIT);

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wd_cnt_d    = wd_cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d     = GRANT_D;
                    bus_req_d   = 1'b1;
                    bus_we_d    = d_we;
                    bus_sel_d   = d_sel;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    wd_cnt_d    = 8'd0;
                    streak_d    = if_req ? streak_q + 4'd1 : 4'd0;
                end else if (if_req) begin
                    state_d     = GRANT_I;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'd0;
                    wd_cnt_d    = 8'd0;
                    streak_d    = 4'd0;
                end
            end

            GRANT_D, GRANT_I: begin
                // A real ack takes precedence over a watchdog expiry in the same cycle.
                if (bus_ack) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (state_q == GRANT_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!bus_we_q) begin
                            d_rdata_d = bus_rdata;
                        end
                    end
                end else if (wd_hit) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == GRANT_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = 32'd0;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!bus_we_q) begin
                            d_rdata_d = 32'd0;
                        end
                    end
                end else if (WD_EN) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            wd_cnt_q    <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wd_cnt_q    <= wd_cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign bus_err   = bus_err_q;

    // Stall the pipeline while any requester is still waiting for its ack.
    assign arb_pause = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// model of the arbitration, latency and watchdog rules.
module tb_mem_bus_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        arb_pause;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .arb_pause (arb_pause),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // reference-model state for the randomized phase
    int          m_streak;
    int          owner;       // 0 none, 1 fetch, 2 data
    int          exp_ack;
    int          wait_left;
    int          if_wait;
    int          d_wait;
    int          n_if_done;
    int          n_d_done;
    logic        prev_idle, prev_ifr, prev_dr;
    logic        if_pend, d_pend;
    logic        o_if_ack, o_d_ack, o_bus_req;
    logic        g_we;
    logic [3:0]  g_sel;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    logic        exp_is_i;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_sel = 4'd0; d_addr = 32'd0; d_wdata = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, bus_err}), 32'd0);
        chk("rst_pause", 32'(arb_pause), 32'd0);
        rst = 1'b0;
        tick();

        // fetch, zero-wait bus
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk("f_pause_n", 32'(arb_pause), 32'd1);
        tick();
        chk("f_bus_req", 32'(bus_req), 32'd1);
        chk("f_bus_addr", bus_addr, 32'h100);
        chk("f_bus_sel", 32'(bus_sel), 32'hF);
        chk("f_bus_we", 32'(bus_we), 32'd0);
        chk("f_pause_n1", 32'(arb_pause), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h24010005;
        tick();
        bus_ack = 1'b0;
        chk("f_bus_req_off", 32'(bus_req), 32'd0);
        chk("f_if_ack", 32'(if_ack), 32'd1);
        chk("f_if_rdata", if_rdata, 32'h24010005);
        chk("f_pause_n2", 32'(arb_pause), 32'd0);
        if_req = 1'b0;
        tick();
        chk("f_if_ack_off", 32'(if_ack), 32'd0);

        // data write with two wait states
        d_req = 1'b1; d_we = 1'b1; d_sel = 4'h3; d_addr = 32'h200; d_wdata = 32'hBEEF;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("w_bus_req", 32'(bus_req), 32'd1);
            chk("w_bus_we", 32'(bus_we), 32'd1);
            chk("w_bus_sel", 32'(bus_sel), 32'h3);
            chk("w_bus_addr", bus_addr, 32'h200);
            chk("w_bus_wdata", bus_wdata, 32'hBEEF);
            chk("w_no_ack", 32'(d_ack), 32'd0);
            bus_ack = (k == 2); bus_rdata = 32'hDEAD0000;
            tick();
        end
        bus_ack = 1'b0;
        chk("w_d_ack", 32'(d_ack), 32'd1);
        chk("w_d_rdata_kept", d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // contention: both requests held high
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h2000; d_wdata = 32'd0;
        tick();
        for (int g = 0; g < 10; g++) begin
            exp_is_i = (g == 4 || g == 9);
            chk("c_bus_req", 32'(bus_req), 32'd1);
            chk("c_owner", bus_addr, exp_is_i ? 32'h1000 : 32'h2000);
            bus_ack = 1'b1; bus_rdata = 32'hA0000000 + 32'(g);
            tick();
            bus_ack = 1'b0;
            chk("c_ack", 32'({if_ack, d_ack}), exp_is_i ? 32'd2 : 32'd1);
            chk("c_rdata", exp_is_i ? if_rdata : d_rdata, 32'hA0000000 + 32'(g));
            if (g == 9) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            tick();
            chk("c_gap", 32'(bus_req), 32'd0);
            tick();
        end
        chk("c_quiet", 32'(bus_req), 32'd0);

        // watchdog on a hung data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; bus_ack = 1'b0; bus_rdata = 32'h55555555;
        tick();
        for (int k = 0; k < TMO; k++) begin
            chk("wd_bus_req", 32'(bus_req), 32'd1);
            chk("wd_no_ack", 32'({d_ack, bus_err}), 32'd0);
            tick();
        end
        chk("wd_d_ack", 32'(d_ack), 32'd1);
        chk("wd_bus_err", 32'(bus_err), 32'd1);
        chk("wd_d_rdata", d_rdata, 32'd0);
        chk("wd_bus_off", 32'(bus_req), 32'd0);
        d_req = 1'b0; bus_ack = 1'b1;
        tick();
        chk("wd_after", 32'({bus_req, d_ack, bus_err}), 32'd0);
        tick();
        bus_ack = 1'b0;
        chk("wd_late_ack", 32'({bus_req, d_ack, bus_err}), 32'd0);
        tick();

        // ack arriving in the watchdog limit cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        tick();
        for (int k = 0; k < TMO - 1; k++) begin
            chk("co_bus_req", 32'(bus_req), 32'd1);
            tick();
        end
        chk("co_bus_req_last", 32'(bus_req), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0;
        chk("co_d_ack", 32'(d_ack), 32'd1);
        chk("co_d_rdata", d_rdata, 32'hCAFEF00D);
        chk("co_bus_err", 32'(bus_err), 32'd0);
        d_req = 1'b0;
        tick();

        // reset in the second GRANT_I cycle
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        chk("r_grant1", 32'(bus_req), 32'd1);
        tick();
        chk("r_grant2", 32'(bus_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_bus_req", 32'(bus_req), 32'd0);
        chk("r_acks", 32'({if_ack, d_ack, bus_err}), 32'd0);
        chk("r_bus_fields", bus_addr | 32'(bus_sel) | bus_wdata | 32'(bus_we), 32'd0);
        chk("r_rdata", if_rdata | d_rdata, 32'd0);
        tick();
        chk("r_refetch", 32'(bus_req), 32'd1);
        chk("r_refetch_addr", bus_addr, 32'h400);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 1'b0;
        chk("r_if_ack", 32'(if_ack), 32'd1);
        chk("r_if_rdata", if_rdata, 32'h12345678);
        if_req = 1'b0;
        tick();

        // randomized traffic against the transaction-level model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_streak = 0; owner = 0; exp_ack = 0; wait_left = 0;
        if_wait = 0; d_wait = 0; n_if_done = 0; n_d_done = 0;
        prev_idle = 1'b1; prev_ifr = 1'b0; prev_dr = 1'b0;
        if_pend = 1'b0; d_pend = 1'b0;
        exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
        g_we = 1'b0; g_sel = 4'd0; g_addr = 32'd0; g_wdata = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            o_if_ack = if_ack; o_d_ack = d_ack; o_bus_req = bus_req;
            chk("rnd_bus_err", 32'(bus_err), 32'd0);
            if (exp_ack == 1) begin
                chk("rnd_if_ack", 32'({if_ack, d_ack}), 32'd2);
                chk("rnd_if_rdata", if_rdata, exp_if_rdata);
                chk("rnd_if_latency", 32'(if_wait <= 80), 32'd1);
                chk("rnd_resp_bus", 32'(bus_req), 32'd0);
                n_if_done++;
            end else if (exp_ack == 2) begin
                chk("rnd_d_ack", 32'({if_ack, d_ack}), 32'd1);
                chk("rnd_d_rdata", d_rdata, exp_d_rdata);
                chk("rnd_d_latency", 32'(d_wait <= 80), 32'd1);
                chk("rnd_resp_bus", 32'(bus_req), 32'd0);
                n_d_done++;
            end else begin
                chk("rnd_no_ack", 32'({if_ack, d_ack}), 32'd0);
            end
            if (exp_ack != 0) begin
                owner = 0;
                exp_ack = 0;
            end

            if (prev_idle) begin
                if (prev_ifr || prev_dr) begin
                    if (prev_dr && !(prev_ifr && m_streak == MAXS)) begin
                        owner = 2;
                        m_streak = prev_ifr ? m_streak + 1 : 0;
                        g_we = d_we; g_sel = d_sel; g_addr = d_addr; g_wdata = d_wdata;
                    end else begin
                        owner = 1;
                        m_streak = 0;
                        g_we = 1'b0; g_sel = 4'hF; g_addr = if_addr; g_wdata = 32'd0;
                    end
                    wait_left = $urandom_range(0, 3);
                    chk("rnd_grant", 32'(bus_req), 32'd1);
                end else begin
                    chk("rnd_stay_idle", 32'(bus_req), 32'd0);
                end
            end

            if (owner != 0) begin
                chk("rnd_bus_req", 32'(bus_req), 32'd1);
                chk("rnd_bus_we", 32'(bus_we), 32'(g_we));
                chk("rnd_bus_sel", 32'(bus_sel), 32'(g_sel));
                chk("rnd_bus_addr", bus_addr, g_addr);
                chk("rnd_bus_wdata", bus_wdata, g_wdata);
                bus_rdata = $urandom;
                if (wait_left == 0) begin
                    bus_ack = 1'b1;
                    exp_ack = owner;
                    if (owner == 1) exp_if_rdata = bus_rdata;
                    else if (!g_we) exp_d_rdata = bus_rdata;
                end else begin
                    wait_left--;
                    bus_ack = 1'b0;
                end
            end else begin
                bus_ack = ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom;
            end

            if (o_if_ack) if_pend = 1'b0;
            if (o_d_ack) d_pend = 1'b0;
            if (if_pend) if_wait++;
            if (d_pend) d_wait++;
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1; if_wait = 0;
                if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1; d_wait = 0;
                d_we = 1'($urandom_range(0, 1));
                d_sel = 4'($urandom_range(0, 15));
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            if_req = if_pend; d_req = d_pend;
            prev_idle = !o_bus_req && !o_if_ack && !o_d_ack;
            prev_ifr = if_req; prev_dr = d_req;
            #1 chk("rnd_pause", 32'(arb_pause), 32'((if_req & ~o_if_ack) | (d_req & ~o_d_ack)));
        end
        chk("rnd_if_traffic", 32'(n_if_done > 20), 32'd1);
        chk("rnd_d_traffic", 32'(n_d_done > 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
